host_pio_master: RTL and testbench
==================================

Name: host_pio_master

Overview:
Avalon-MM initiator that drives the simple PIO-style slaves on the host fabric, such as the cartridge-type select port. It accepts single read/write commands on a valid/ready interface and issues one transaction on the bus: chipselect, write_n, 2-bit address and 32-bit writedata. For reads it captures readdata and returns a one-cycle response. It lets cartridge/control logic reach PIO registers without a soft CPU.

Parameters:
READ_WAIT, 0, extra bus cycles chipselect is held before readdata is sampled; legal range 0..15
ADDR_W, 2, bus address width
DATA_W, 32, bus data width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_write  in  1  1 = write, 0 = read
cmd_address  in  ADDR_W  target register
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse for every accepted command
rsp_rdata  out  DATA_W  read result; valid with rsp_valid on reads
address  out  ADDR_W  bus address
chipselect  out  1  bus select
write_n  out  1  bus write strobe, active low
writedata  out  DATA_W  bus write data
readdata  in  DATA_W  bus read data; combinational from the slave, zero-latency

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: state IDLE, cmd_ready 1, chipselect 0, write_n 1, address 0, writedata 0, rsp_valid 0, rsp_rdata 0, wait counter 0.
- States and transitions: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register cmd_write, cmd_address and cmd_wdata, then go to ACCESS.
  - Command inputs are ignored at all other times; later changes to them have no effect.
- ACCESS, write:
  - Exactly 1 cycle with chipselect=1, write_n=0, address/writedata = the registered values.
  - Then go to RESP.
- ACCESS, read:
  - chipselect=1, write_n=1 for 1+READ_WAIT cycles, counted by a wait counter of width clog2(READ_WAIT+1), minimum 1.
  - readdata is captured into rsp_rdata at the rising edge ending the last ACCESS cycle.
  - Then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; chipselect=0, write_n=1.
  - Go to IDLE. rsp_rdata is unchanged on writes.
- cmd_ready is 0 in ACCESS and RESP; only one command is outstanding at a time.
- Latency, handshake edge to rsp_valid high: write 2 cycles; read 2+READ_WAIT cycles. Back-to-back write throughput is one command per 3 cycles.
- address and writedata hold their last driven value while idle; only chipselect and write_n mark a valid access.
- chipselect and write_n are registered outputs with no glitches. write_n is never 0 while chipselect is 0.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The in-flight command is dropped with no rsp_valid; no partial write may occur after reset release.
- cmd_valid asserted in the same cycle as RESP is not accepted until the following IDLE cycle.

Decomposition:
- Shared package host_pio_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - ADDR_W and DATA_W defaults
  - READ_WAIT_MAX = 15
- No sub-module needed; the wait counter is inline.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles and release -> cmd_ready=1, chipselect=0, write_n=1, rsp_valid=0, rsp_rdata=0.
- Write to 8-bit PIO slave model: cmd_write=1, addr=0, wdata=0x000000A5 -> exactly one cycle of chipselect=1/write_n=0 one cycle after handshake; rsp_valid 2 cycles after handshake; slave out_port=0xA5.
- Read-back, READ_WAIT=0: read addr 0 after the previous write -> rsp_rdata=0x000000A5 with rsp_valid 2 cycles after handshake; read addr 1 -> rsp_rdata=0.
- READ_WAIT=3: read with slave readdata changed to 0x5A during the 4th ACCESS cycle only -> chipselect high for 4 cycles; rsp_rdata=0x5A; latency 5.
- Back-to-back: cmd_valid held high for 3 writes (0x01, 0x02, 0x03) -> accepted at cycles 0, 3, 6; cmd_ready low in between; out_port ends at 0x03; three rsp_valid pulses.
- Reset mid-read: assert reset_n=0 during ACCESS with READ_WAIT=3 -> chipselect drops immediately; no rsp_valid; after release, a fresh write of 0x7E completes normally.

Source files
------------

// File: rtl/host_pio_pkg.sv
// Shared types and defaults for the host PIO Avalon-MM initiator.
// Imported by host_pio_master.
package host_pio_pkg;

    localparam int ADDR_W_DFLT   = 2;
    localparam int DATA_W_DFLT   = 32;
    localparam int READ_WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/host_pio_master.sv
// Single-outstanding Avalon-MM initiator for simple PIO slaves.
// One command in, one bus access out, one-cycle completion pulse back.
module host_pio_master
    import host_pio_pkg::*;
#(
    parameter int READ_WAIT = 0,
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int DATA_W    = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);

    localparam int CNT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              ready_q, ready_d;
    logic              cs_q, cs_d;
    logic              wen_q, wen_d;
    logic              rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            cs_q        <= 1'b0;
            wen_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            wen_q       <= wen_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = ACCESS;
            ACCESS:  if (wr_q || cnt_q == CNT_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes are computed from the next state so they leave a flop clean.
    always_comb begin
        wr_d        = wr_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = '0;
        cs_d        = 1'b0;
        wen_d       = 1'b1;
        if (state_q == IDLE && cmd_valid) begin
            wr_d        = cmd_write;
            address_d   = cmd_address;
            writedata_d = cmd_wdata;
        end
        if (state_q == ACCESS && state_d == ACCESS) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ACCESS && state_d == RESP && !wr_q) begin
            rsp_rdata_d = readdata;
        end
        if (state_d == ACCESS) begin
            cs_d  = 1'b1;
            wen_d = ~wr_d;
        end
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign address    = address_q;
    assign chipselect = cs_q;
    assign write_n    = wen_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_host_pio_master.sv
// Bench for host_pio_master: two instances (READ_WAIT 0 and 3), each
// driving a small PIO slave, checked against a register-map model.
module tb_host_pio_master;
    import host_pio_pkg::*;

    localparam int AW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic          cmd_write [2];
    logic [AW-1:0] cmd_address [2];
    logic [DW-1:0] cmd_wdata [2];
    logic          rsp_valid [2];
    logic [DW-1:0] rsp_rdata [2];
    logic [AW-1:0] address [2];
    logic          chipselect [2];
    logic          write_n [2];
    logic [DW-1:0] writedata [2];
    logic [DW-1:0] readdata [2];
    logic          ovr_en [2];
    logic [DW-1:0] ovr_val [2];
    logic [7:0]    out_port [2];

    logic [DW-1:0] mdl [2][4];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [DW-1:0] regs [4];

        host_pio_master #(
            .READ_WAIT(g * 3),
            .ADDR_W(AW),
            .DATA_W(DW)
        ) u_dut (
            .clk(clk),
            .reset_n(reset_n),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_write(cmd_write[g]),
            .cmd_address(cmd_address[g]),
            .cmd_wdata(cmd_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .address(address[g]),
            .chipselect(chipselect[g]),
            .write_n(write_n[g]),
            .writedata(writedata[g]),
            .readdata(readdata[g])
        );

        // Slave: reg0 8-bit out_port, reg1 reads zero, reg2/3 full width.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int r = 0; r < 4; r++) regs[r] <= '0;
            end else if (chipselect[g] && !write_n[g] && address[g] != 2'd1) begin
                regs[address[g]] <= (address[g] == 2'd0) ?
                    {24'b0, writedata[g][7:0]} : writedata[g];
            end
        end

        assign readdata[g] = ovr_en[g] ? ovr_val[g] :
            (address[g] == 2'd1) ? '0 : regs[address[g]];
        assign out_port[g] = regs[0][7:0];
    end

    function automatic logic [DW-1:0] model_rd(int i, logic [AW-1:0] a);
        if (a == 2'd0) return {24'b0, mdl[i][0][7:0]};
        if (a == 2'd1) return '0;
        return mdl[i][a];
    endfunction

    task automatic model_wr(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        if (a == 2'd0) mdl[i][0] = {24'b0, d[7:0]};
        else if (a != 2'd1) mdl[i][a] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 4; r++) mdl[i][r] = '0;
    endtask

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic do_cmd(int i, bit wr, logic [AW-1:0] a, logic [DW-1:0] d,
                          int ovr_cyc, logic [DW-1:0] ovr_v);
        int rw, cs_n, we_n, bad, lat, rsps, rdy_lo;
        logic [DW-1:0] exp, prev, got;
        rw = (i == 0) ? 0 : 3;
        exp = (ovr_cyc != 0) ? ovr_v : model_rd(i, a);
        prev = rsp_rdata[i];
        cs_n = 0; we_n = 0; bad = 0; lat = 0; rsps = 0; rdy_lo = 0; got = '0;
        chk("ready_before", cmd_ready[i], 1);
        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_address[i] = a;
        cmd_wdata[i] = d;
        ovr_val[i] = ovr_v;
        @(posedge clk);
        #1;
        cmd_valid[i] = 1'b0;
        cmd_write[i] = ~wr;
        cmd_address[i] = AW'($urandom);
        cmd_wdata[i] = $urandom;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == ovr_cyc) ovr_en[i] = 1'b1;
            if (ovr_cyc != 0 && k == ovr_cyc + 1) ovr_en[i] = 1'b0;
            if (k == 1) begin
                chk("bus_addr", address[i], a);
                if (wr) chk("bus_wdata", writedata[i], d);
            end
            if (chipselect[i]) cs_n++;
            if (chipselect[i] && !write_n[i]) we_n++;
            if (!chipselect[i] && !write_n[i]) bad++;
            if (!cmd_ready[i]) rdy_lo++;
            if (rsp_valid[i]) begin
                rsps++;
                if (lat == 0) begin
                    lat = k;
                    got = rsp_rdata[i];
                end
            end
        end
        chk("latency", lat, wr ? 2 : 2 + rw);
        chk("cs_cycles", cs_n, wr ? 1 : 1 + rw);
        chk("wr_strobes", we_n, wr ? 1 : 0);
        chk("wn_without_cs", bad, 0);
        chk("rsp_pulses", rsps, 1);
        chk("ready_low", rdy_lo, lat);
        if (wr) begin
            model_wr(i, a, d);
            chk("rdata_kept", got, prev);
            chk("out_port", out_port[i], mdl[i][0][7:0]);
        end else begin
            chk("rdata", got, exp);
        end
    endtask

    task automatic back_to_back();
        int cyc, n, rdy_lo, rsps;
        int acc [3];
        cyc = 0; n = 0; rdy_lo = 0; rsps = 0;
        for (int j = 0; j < 3; j++) acc[j] = -1;
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_address[0] = '0;
        cmd_wdata[0] = 32'h1;
        while (n < 3 && cyc < 20) begin
            if (rsp_valid[0]) rsps++;
            if (cmd_ready[0]) begin
                acc[n] = cyc;
                n++;
            end else begin
                rdy_lo++;
            end
            @(posedge clk);
            #1;
            if (n < 3) cmd_wdata[0] = DW'(n + 1);
            else cmd_valid[0] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        repeat (4) begin
            if (rsp_valid[0]) rsps++;
            @(negedge clk);
        end
        cmd_valid[0] = 1'b0;
        chk("b2b_accepted", n, 3);
        chk("b2b_acc0", acc[0], 0);
        chk("b2b_acc1", acc[1], 3);
        chk("b2b_acc2", acc[2], 6);
        chk("b2b_ready_low", rdy_lo, 4);
        chk("b2b_rsps", rsps, 3);
        model_wr(0, 2'd0, 32'h3);
        chk("b2b_out_port", out_port[0], 8'h03);
    endtask

    initial begin
        int rsps;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_write[i] = 1'b0;
            cmd_address[i] = '0;
            cmd_wdata[i] = '0;
            ovr_en[i] = 1'b0;
            ovr_val[i] = '0;
        end
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", cmd_ready[i], 1);
            chk("rst_cs", chipselect[i], 0);
            chk("rst_wn", write_n[i], 1);
            chk("rst_rsp_valid", rsp_valid[i], 0);
            chk("rst_rdata", rsp_rdata[i], 0);
            chk("rst_addr", address[i], 0);
            chk("rst_wdata", writedata[i], 0);
        end

        do_cmd(0, 1'b1, 2'd0, 32'h0000_00A5, 0, '0);
        do_cmd(0, 1'b0, 2'd0, 32'h0, 0, '0);
        do_cmd(0, 1'b0, 2'd1, 32'h0, 0, '0);
        do_cmd(1, 1'b1, 2'd0, 32'h0000_00A5, 0, '0);
        do_cmd(1, 1'b0, 2'd0, 32'h0, 4, 32'h0000_005A);
        back_to_back();

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                do_cmd(i, 1'($urandom), AW'($urandom), $urandom, 0, '0);
            end
        end

        cmd_valid[1] = 1'b1;
        cmd_write[1] = 1'b0;
        cmd_address[1] = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_cs_before", chipselect[1], 1);
        reset_n = 1'b0;
        #1;
        chk("mid_cs_async", chipselect[1], 0);
        chk("mid_wn_async", write_n[1], 1);
        chk("mid_rsp_async", rsp_valid[1], 0);
        chk("mid_rdata_async", rsp_rdata[1], 0);
        chk("mid_ready_async", cmd_ready[1], 1);
        model_reset();
        rsps = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[1]) rsps++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[1] || chipselect[1]) rsps++;
        end
        chk("mid_no_activity", rsps, 0);
        do_cmd(1, 1'b1, 2'd0, 32'h0000_007E, 0, '0);
        chk("mid_out_port", out_port[1], 8'h7E);
        do_cmd(1, 1'b0, 2'd0, 32'h0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
